wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter sitting directly upstream of the register file write port. Merges results from the single-cycle ALU path (port A, never stalled) and a multicycle unit (port B, valid/ready, buffered in a small FIFO). Produces at most one register-file write per cycle on `we`/`wa`/`din`. Writes targeting register 0 are discarded, so downstream never sees `we` with `wa==0`.

## Interface
- `DEPTH`, 4: port-B FIFO entries; power of two, ≥2
- `DW`, 32: data width
- `AW`, 5: register address width
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `a_valid`  in  1  ALU result valid this cycle
- `a_rd`  in  AW  ALU destination register
- `a_data`  in  DW  ALU result
- `b_valid`  in  1  multicycle result valid
- `b_ready`  out  1  arbiter accepts B this cycle
- `b_rd`  in  AW  B destination register
- `b_data`  in  DW  B result
- `we`  out  1  register-file write enable
- `wa`  out  AW  register-file write address
- `din`  out  DW  register-file write data
- `occupancy`  out  $clog2(DEPTH)+1  FIFO entry count

## Operation
- A is effective when `a_valid && a_rd!=0`. B is accepted when `b_valid && b_ready`. An accepted B with `b_rd==0` is consumed and dropped, and is not stored.
- FIFO holds {rd, data}. Push happens on an accepted B with nonzero rd that is not bypassed. Pop happens when the head is written.
- Write select each cycle, in priority order:
  1. Effective A: `we=1`, `wa=a_rd`, `din=a_data`. FIFO does not pop.
  2. Otherwise, FIFO non-empty: write the head and pop.
  3. Otherwise, bypass case (see Configuration).
  4. Otherwise `we=0`; `wa`/`din` are don't-care but driven 0.
- A always wins. B entries are written strictly in acceptance order.
- The arbiter performs no same-register ordering between A and B. The issue logic must not issue an ALU op whose rd matches an outstanding B rd.
- `b_ready = !rst && occupancy<DEPTH`. It depends only on registered state, with no combinational path from `a_valid`. When full, a pop in the same cycle does not raise `b_ready`.
- Push and pop in the same cycle leave `occupancy` unchanged. Read/write pointers wrap modulo DEPTH.

## Timing
- `we`/`wa`/`din` are combinational from A inputs and the FIFO head. The register file captures them at the next edge.
- Port A: result presented in cycle N is written at the end of cycle N, latency 0.
- Port B without bypass: accepted at the end of cycle N, written no earlier than the end of cycle N+1. Each cycle of continuous A traffic adds one cycle.
- Reset: on the edge with `rst=1`, pointers and `occupancy` clear to 0 and entries are invalidated. While `rst=1`, `b_ready=0` and `we=0`. Reset mid-stream discards all buffered B results.
- Sustained B with no A: one write per cycle, FIFO does not grow.
- Sustained A: FIFO fills. `b_ready` drops the cycle `occupancy` reaches DEPTH.

## Configuration
- `WB_BYPASS_EN` defined: when A is not effective, the FIFO is empty, and B is accepted with nonzero rd, B is written in the same cycle (`wa=b_rd`, `din=b_data`) and not pushed. Latency is 0.
- Not defined: every nonzero-rd B is pushed, minimum latency 1. There is no combinational path from `b_*` to `we`/`wa`/`din`.

## Structure
- Package `wb_pkg`:
  - `wb_entry_t` struct {rd[AW], data[DW]}
  - `REG_ZERO` constant (5'd0)
  - default DEPTH/DW/AW constants
- Sub-module `wb_fifo`: synchronous FIFO of `wb_entry_t` with push/pop/full/empty/count. The arbiter holds only the select mux and ready logic.

## Test plan
- Reset: assert `rst` 2 cycles with `b_valid=1` → `b_ready=0`, `we=0`, `occupancy=0`. Release → `b_ready=1`.
- A only: `a_valid=1`, `a_rd=3`, `a_data=0xDEADBEEF` → same cycle `we=1`, `wa=3`, `din=0xDEADBEEF`. With `a_rd=0` → `we=0`.
- Contention: A valid 6 consecutive cycles while B offers rd=5..10 → 4 accepted, `b_ready=0` at occupancy 4. After A stops, writes occur in order rd 5,6,7,8 on consecutive cycles, then B resumes with rd 9.
- Bypass: idle FIFO, B rd=7 data=0x12 → same-cycle write with macro defined, next-cycle write without. `occupancy` stays 0 with macro, peaks at 1 without.
- Zero-rd drop: B rd=0 accepted → no write, `occupancy` unchanged.
- Mid-operation reset: 3 entries buffered, assert `rst` 1 cycle → `occupancy=0`, no subsequent write of those entries.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and default sizing for the writeback arbiter slice.
package wb_pkg;

  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned AW_DEF    = 5;

  localparam logic [AW_DEF-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [AW_DEF-1:0] rd;
    logic [DW_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; head is readable combinationally.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  wb_entry_t              din,
  output wb_entry_t              head_c,
  output logic                   full_c,
  output logic                   empty_c,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t         mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     cnt;

  // Storage is not reset; cleared pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head_c  = mem[rd_ptr];
  assign full_c  = (cnt == CW'(DEPTH));
  assign empty_c = (cnt == '0);
  assign count   = cnt;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU port A always wins, port B is buffered in order.
// Optional same-cycle B bypass into an idle arbiter: define WB_BYPASS_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  input  logic [AW-1:0]          a_rd,
  input  logic [DW-1:0]          a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [AW-1:0]          b_rd,
  input  logic [DW-1:0]          b_data,
  output logic                   we,
  output logic [AW-1:0]          wa,
  output logic [DW-1:0]          din,
  output logic [$clog2(DEPTH):0] occupancy
);

  wb_entry_t push_entry;
  wb_entry_t head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      a_eff;
  logic      b_keep;
  logic      bypass;
  logic      push;
  logic      pop;

  // Ready depends only on reset and registered fill level.
  assign b_ready = !rst && !fifo_full;

  assign push_entry.rd   = AW_DEF'(b_rd);
  assign push_entry.data = DW_DEF'(b_data);

  // Write select: A, then FIFO head, then (optionally) bypassed B.
  always_comb begin
    a_eff  = a_valid && (a_rd != AW'(REG_ZERO));
    b_keep = b_valid && b_ready && (b_rd != AW'(REG_ZERO));
    bypass = 1'b0;
    pop    = 1'b0;
    we     = 1'b0;
    wa     = '0;
    din    = '0;
    if (rst) begin
      we = 1'b0;
    end else if (a_eff) begin
      we  = 1'b1;
      wa  = a_rd;
      din = a_data;
    end else if (!fifo_empty) begin
      we  = 1'b1;
      wa  = AW'(head.rd);
      din = DW'(head.data);
      pop = 1'b1;
`ifdef WB_BYPASS_EN
    end else if (b_keep) begin
      bypass = 1'b1;
      we     = 1'b1;
      wa     = b_rd;
      din    = b_data;
`endif
    end
    push = b_keep && !bypass;
  end

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .din    (push_entry),
    .head_c (head),
    .full_c (fifo_full),
    .empty_c(fifo_empty),
    .count  (occupancy)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic
// checked against an in-order scoreboard of accepted B results.
module tb_wb_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          a_valid;
  logic [AW-1:0] a_rd;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_rd;
  logic [DW-1:0] b_data;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] din;
  logic [CW-1:0] occupancy;

  int total = 0;
  int bad   = 0;
  int k;

  logic [AW+DW-1:0] b_exp [$];
  logic [AW+DW-1:0] e;

  wb_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_rd     (a_rd),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_rd     (b_rd),
    .b_data   (b_data),
    .we       (we),
    .wa       (wa),
    .din      (din),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0;
    a_rd    = '0;
    a_data  = '0;
    b_valid = 1'b0;
    b_rd    = '0;
    b_data  = '0;
  endtask

  // Scoreboard: accepted nonzero-rd B results queue up; every non-A write pops one.
  always @(negedge clk) begin
    if (rst) begin
      check_val("rst_we", 64'(we), 64'(0));
      b_exp.delete();
    end else begin
      if (b_valid && b_ready && (b_rd != '0)) b_exp.push_back({b_rd, b_data});
      if (a_valid && (a_rd != '0)) begin
        check_val("a_we", 64'(we), 64'(1));
        check_val("a_wa", 64'(wa), 64'(a_rd));
        check_val("a_din", 64'(din), 64'(a_data));
      end else if (we) begin
        check_val("we_wa_zero", 64'(wa == '0), 64'(0));
        check_val("sb_pending", 64'(b_exp.size() > 0), 64'(1));
        if (b_exp.size() > 0) begin
          e = b_exp.pop_front();
          check_val("b_wa", 64'(wa), 64'(e[AW+DW-1:DW]));
          check_val("b_din", 64'(din), 64'(e[DW-1:0]));
        end
      end
    end
  end

  initial begin
    idle();
    rst     = 1'b1;
    b_valid = 1'b1;
    b_rd    = 5'd5;
    b_data  = 32'h55;
    #1;

    // reset held two cycles with B offered
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("rst_ready", 64'(b_ready), 64'(0));
      check_val("rst_we_d", 64'(we), 64'(0));
      check_val("rst_occ", 64'(occupancy), 64'(0));
      next_cyc();
    end
    rst = 1'b0;
    idle();
    @(negedge clk);
    check_val("rel_ready", 64'(b_ready), 64'(1));
    check_val("rel_occ", 64'(occupancy), 64'(0));

    // A only
    next_cyc();
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hDEADBEEF;
    @(negedge clk);
    check_val("aonly_we", 64'(we), 64'(1));
    check_val("aonly_wa", 64'(wa), 64'(3));
    check_val("aonly_din", 64'(din), 64'hDEADBEEF);
    next_cyc();
    a_rd = 5'd0;
    @(negedge clk);
    check_val("a_zero_we", 64'(we), 64'(0));
    next_cyc();

    // contention: A for 6 cycles while B offers rd 5..10
    k = 0;
    for (int i = 0; i < 6; i++) begin
      a_valid = 1'b1; a_rd = 5'(20 + i); a_data = 32'hA000_0000 + 32'(i);
      b_valid = 1'b1; b_rd = 5'(5 + k);  b_data = 32'hB000_0000 + 32'(5 + k);
      @(negedge clk);
      check_val("cont_occ", 64'(occupancy), 64'((i < 4) ? i : 4));
      check_val("cont_ready", 64'(b_ready), 64'(i < 4));
      if (b_ready) k++;
      next_cyc();
    end
    a_valid = 1'b0; a_rd = '0;
    for (int j = 0; j < 4; j++) begin
      b_valid = (k < 6); b_rd = 5'(5 + k); b_data = 32'hB000_0000 + 32'(5 + k);
      @(negedge clk);
      check_val("drain_we", 64'(we), 64'(1));
      check_val("drain_wa", 64'(wa), 64'(5 + j));
      if (j == 0) check_val("full_pop_ready", 64'(b_ready), 64'(0));
      if (b_valid && b_ready) k++;
      next_cyc();
    end
    idle();
    for (int t = 0; t < 8 && occupancy != '0; t++) next_cyc();
    @(negedge clk);
    check_val("drain_occ", 64'(occupancy), 64'(0));
    check_val("drain_sb", 64'(b_exp.size()), 64'(0));
    next_cyc();

    // bypass into an idle arbiter
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h12;
    @(negedge clk);
`ifdef WB_BYPASS_EN
    check_val("byp_we0", 64'(we), 64'(1));
    check_val("byp_wa0", 64'(wa), 64'(7));
    check_val("byp_din0", 64'(din), 64'h12);
`else
    check_val("byp_we0", 64'(we), 64'(0));
`endif
    next_cyc();
    idle();
    @(negedge clk);
`ifdef WB_BYPASS_EN
    check_val("byp_occ1", 64'(occupancy), 64'(0));
    check_val("byp_we1", 64'(we), 64'(0));
`else
    check_val("byp_occ1", 64'(occupancy), 64'(1));
    check_val("byp_we1", 64'(we), 64'(1));
    check_val("byp_wa1", 64'(wa), 64'(7));
`endif
    next_cyc();
    @(negedge clk);
    check_val("byp_occ2", 64'(occupancy), 64'(0));

    // zero-rd B is consumed and dropped
    next_cyc();
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hCAFE;
    @(negedge clk);
    check_val("z_ready", 64'(b_ready), 64'(1));
    check_val("z_we", 64'(we), 64'(0));
    next_cyc();
    idle();
    @(negedge clk);
    check_val("z_occ", 64'(occupancy), 64'(0));
    check_val("z_we1", 64'(we), 64'(0));
    next_cyc();

    // mid-operation reset with three buffered entries
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_rd = 5'd1; a_data = 32'(i);
      b_valid = 1'b1; b_rd = 5'(11 + i); b_data = 32'hC0 + 32'(i);
      next_cyc();
    end
    idle();
    @(negedge clk);
    check_val("mr_occ3", 64'(occupancy), 64'(3));
    rst = 1'b1;
    @(negedge clk);
    check_val("mr_ready", 64'(b_ready), 64'(0));
    next_cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("mr_occ0", 64'(occupancy), 64'(0));
      check_val("mr_we", 64'(we), 64'(0));
      next_cyc();
    end

    // random mixed traffic
    for (int i = 0; i < 400; i++) begin
      a_valid = ($urandom_range(0, 2) == 0);
      a_rd    = 5'($urandom_range(0, 31));
      a_data  = $urandom;
      b_valid = ($urandom_range(0, 1) == 1);
      b_rd    = 5'($urandom_range(0, 31));
      b_data  = $urandom;
      next_cyc();
    end
    idle();
    for (int t = 0; t < 20 && occupancy != '0; t++) next_cyc();
    @(negedge clk);
    check_val("rand_occ", 64'(occupancy), 64'(0));
    check_val("rand_sb", 64'(b_exp.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
